image_rom_arbiter: RTL

Round-robin arbiter sharing one synchronous image ROM read port among up to NUM_REQ drawing requesters, e.g. several sprite/digit drawers in the draw_image pipeline. It grants one read per clock, drives a registered ROM address, and tags each in-flight read so the returned pixel is steered back to its requester with a valid strobe. An optional per-requester lock holds the grant for burst reads along an image row.

---
 rtl/image_rom_arbiter_if.sv | 26 ++
 rtl/image_rom_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/image_rom_arbiter_if.sv
// Requester/ROM bundle shared by the image ROM arbiter and whatever drives it.
// The master side drives requests and ROM read data; the slave side is the arbiter.
interface image_rom_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 12
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            lock;
   logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
   logic [NUM_REQ-1:0]            gnt;
   logic [ADDR_WIDTH-1:0]         rom_address;
   logic [DATA_WIDTH-1:0]         rom_rgb;
   logic [NUM_REQ-1:0]            rd_valid;
   logic [DATA_WIDTH-1:0]         rd_data;

   modport master (
      output req, lock, addr, rom_rgb,
      input  gnt, rom_address, rd_valid, rd_data
   );

   modport slave (
      input  req, lock, addr, rom_rgb,
      output gnt, rom_address, rd_valid, rd_data
   );
endinterface

// File: rtl/image_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous image ROM read port, with burst lock
// and a tag pipeline that steers each returned pixel back to its requester.
module image_rom_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_WIDTH  = 14,
   parameter int DATA_WIDTH  = 12,
   parameter int ROM_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   image_rom_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic                  own_v_q, own_v_d;
   logic [ID_W-1:0]       own_id_q, own_id_d;
   logic [ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
   logic                  tag_v_q  [0:ROM_LATENCY];
   logic [ID_W-1:0]       tag_id_q [0:ROM_LATENCY];

   logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
   logic                  rr_hit;
   logic [ID_W-1:0]       rr_id;
   logic                  hold;
   logic                  win_v;
   logic [ID_W-1:0]       win_id;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign addr_a[gi]       = bus.addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign bus.gnt[gi]      = win_v && (win_id == ID_W'(gi));
         assign bus.rd_valid[gi] = tag_v_q[ROM_LATENCY] && (tag_id_q[ROM_LATENCY] == ID_W'(gi));
      end
   endgenerate

   // Scan offsets from farthest to nearest so the closest requester after ptr wins.
   always_comb begin
      logic [ID_W:0] idx;
      idx    = '0;
      rr_hit = 1'b0;
      rr_id  = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = {1'b0, ptr_q} + (ID_W+1)'(off);
         if (idx >= (ID_W+1)'(NUM_REQ)) begin
            idx = idx - (ID_W+1)'(NUM_REQ);
         end
         if (bus.req[idx[ID_W-1:0]]) begin
            rr_hit = 1'b1;
            rr_id  = idx[ID_W-1:0];
         end
      end
   end

   // A locked owner only keeps the port while it is still requesting.
   assign hold   = own_v_q && bus.req[own_id_q];
   assign win_v  = rst_n && (hold || rr_hit);
   assign win_id = hold ? own_id_q : rr_id;

   always_comb begin
      ptr_d         = ptr_q;
      own_v_d       = 1'b0;
      own_id_d      = own_id_q;
      rom_address_d = rom_address_q;
      if (win_v) begin
         rom_address_d = addr_a[win_id];
         if (bus.lock[win_id]) begin
            own_v_d  = 1'b1;
            own_id_d = win_id;
         end else if (win_id == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_id + ID_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q         <= '0;
         own_v_q       <= 1'b0;
         own_id_q      <= '0;
         rom_address_q <= '0;
         tag_v_q[0]    <= 1'b0;
         tag_id_q[0]   <= '0;
      end else begin
         ptr_q         <= ptr_d;
         own_v_q       <= own_v_d;
         own_id_q      <= own_id_d;
         rom_address_q <= rom_address_d;
         tag_v_q[0]    <= win_v;
         tag_id_q[0]   <= win_id;
      end
   end

   // Tags advance every clock; the ROM never stalls so neither does the return path.
   generate
      for (gi = 1; gi <= ROM_LATENCY; gi++) begin : g_tag
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               tag_v_q[gi]  <= 1'b0;
               tag_id_q[gi] <= '0;
            end else begin
               tag_v_q[gi]  <= tag_v_q[gi-1];
               tag_id_q[gi] <= tag_id_q[gi-1];
            end
         end
      end
   endgenerate

   assign bus.rom_address = rom_address_q;
   assign bus.rd_data     = bus.rom_rgb;
endmodule
